mac_result_serializer: RTL and testbench

MAC_RESULT_SERIALIZER -- requirements
Module: mac_result_serializer

---
 rtl/mac_result_serializer_if.sv | 24 ++
 rtl/mac_result_serializer.sv | 124 ++++++++++++
 tb/tb_mac_result_serializer.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_result_serializer_if.sv
// Output stream of the MAC result serializer: one word per beat with a
// valid/ready handshake and an end-of-frame marker.
interface mac_result_serializer_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/mac_result_serializer.sv
// Snapshots a 512-bit MAC accumulator and streams it out as 512/WORD_W
// words, least-significant word first, over a valid/ready handshake.
// Define SER_CHECKSUM_EN to append an XOR checksum word to every frame.
module mac_result_serializer #(
  parameter int WORD_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [511:0]            acc_in,
  input  logic                    snap,
  mac_result_serializer_if.master ser,
  output logic                    busy,
  output logic                    overrun,
  output logic [15:0]             frame_cnt
);
  localparam int unsigned NW    = 512 / WORD_W;
  localparam int unsigned IDX_W = $clog2(NW);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NW - 1);

`ifdef SER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, SEND, CSUM} state_t;
`else
  typedef enum logic {IDLE, SEND} state_t;
`endif

  state_t             state;
  logic [511:0]       shadow;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   next_idx;
  logic [WORD_W-1:0]  next_word;
  logic               xfer;
  logic               last_xfer;
  logic               start;

  // Handshake decode; a new frame may start from IDLE or on the final beat.
  always_comb begin
    xfer      = ser.out_valid & ser.out_ready;
    last_xfer = xfer & ser.out_last;
    start     = snap & ((state == IDLE) | last_xfer);
    next_idx  = idx + IDX_W'(1);
    next_word = shadow[next_idx*WORD_W +: WORD_W];
  end

`ifdef SER_CHECKSUM_EN
  logic [WORD_W-1:0] csum;

  // XOR of every data word of the captured frame.
  always_comb begin
    csum = '0;
    for (int unsigned i = 0; i < NW; i++) begin
      csum = csum ^ shadow[i*WORD_W +: WORD_W];
    end
  end
`endif

  // Frame sequencer with registered stream outputs and status flags.
  // out_data is preloaded with the next word on each transfer so the
  // stream output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      shadow        <= '0;
      ser.out_data  <= '0;
      ser.out_valid <= 1'b0;
      ser.out_last  <= 1'b0;
      busy          <= 1'b0;
      overrun       <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      if (snap && busy && !last_xfer) begin
        overrun <= 1'b1;
      end
      if (last_xfer) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (start) begin
        state         <= SEND;
        shadow        <= acc_in;
        idx           <= '0;
        ser.out_data  <= acc_in[WORD_W-1:0];
        ser.out_valid <= 1'b1;
        ser.out_last  <= 1'b0;
        busy          <= 1'b1;
      end else begin
        case (state)
          SEND: begin
            if (xfer) begin
              if (idx == LAST_IDX) begin
`ifdef SER_CHECKSUM_EN
                state        <= CSUM;
                ser.out_data <= csum;
                ser.out_last <= 1'b1;
`else
                state         <= IDLE;
                ser.out_valid <= 1'b0;
                ser.out_last  <= 1'b0;
                busy          <= 1'b0;
`endif
              end else begin
                idx          <= next_idx;
                ser.out_data <= next_word;
`ifndef SER_CHECKSUM_EN
                ser.out_last <= (next_idx == LAST_IDX);
`endif
              end
            end
          end
`ifdef SER_CHECKSUM_EN
          CSUM: begin
            if (xfer) begin
              state         <= IDLE;
              ser.out_valid <= 1'b0;
              ser.out_last  <= 1'b0;
              busy          <= 1'b0;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mac_result_serializer.sv
// Randomized self-checking bench for mac_result_serializer (WORD_W=32).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mac_result_serializer;
  localparam int W  = 32;
  localparam int NW = 512 / W;
`ifdef SER_CHECKSUM_EN
  localparam int FLEN = NW + 1;
`else
  localparam int FLEN = NW;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] acc_in;
  logic         snap;
  logic         busy;
  logic         overrun;
  logic [15:0]  frame_cnt;

  mac_result_serializer_if #(.WORD_W(W)) bus ();

  mac_result_serializer #(.WORD_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .acc_in    (acc_in),
    .snap      (snap),
    .ser       (bus.master),
    .busy      (busy),
    .overrun   (overrun),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int           errors = 0;
  int           checks = 0;
  logic [15:0]  exp_cnt;
  logic [W-1:0] got_data[$];
  logic         got_last[$];
  bit           got_timeout;

  // Reference: word k of a frame is slice k of the snapshot; the extra
  // word (checksum build only) is the XOR of all data slices.
  function automatic logic [W-1:0] model_word(input logic [511:0] acc, input int k);
    logic [W-1:0] x;
    x = '0;
    if (k < NW) return acc[k*W +: W];
    for (int i = 0; i < NW; i++) x = x ^ acc[i*W +: W];
    return x;
  endfunction

  function automatic logic [511:0] rand_acc();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic start_frame(input logic [511:0] acc);
    acc_in = acc;
    snap   = 1'b1;
    @(negedge clk);
    snap   = 1'b0;
  endtask

  // Receives words until the out_last beat; returns one edge after it.
  task automatic collect_frame(input int ready_pct, input bit scramble);
    got_data.delete();
    got_last.delete();
    got_timeout = 1'b0;
    for (int c = 0; c < 400; c++) begin
      bus.out_ready = (int'($urandom_range(99)) < ready_pct);
      if (scramble) acc_in = rand_acc();
      if (bus.out_valid && bus.out_ready) begin
        got_data.push_back(bus.out_data);
        got_last.push_back(bus.out_last);
        if (bus.out_last) begin
          @(negedge clk);
          bus.out_ready = 1'b0;
          return;
        end
      end
      @(negedge clk);
    end
    got_timeout = 1'b1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; snap = 1'b0; bus.out_ready = 1'b0; acc_in = rand_acc();
    repeat (2) @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", bus.out_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
    checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL reset_data: got %0h expected 0", bus.out_data); end
    rst = 1'b0;
    exp_cnt = 16'd0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [511:0] a;
    a = 512'd21;
    start_frame(a);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency_valid: got %b expected 1", bus.out_valid); end
    checks++; if (bus.out_data !== 32'd21) begin errors++; $display("FAIL basic_first_word: got %0d expected 21", bus.out_data); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
    collect_frame(100, 1'b1);
    checks++; if (got_timeout || got_data.size() != FLEN) begin errors++; $display("FAIL basic_len: got %0d words expected %0d", got_data.size(), FLEN); end
    for (int k = 0; k < got_data.size() && k < FLEN; k++) begin
      checks++; if (got_data[k] !== model_word(a, k)) begin errors++; $display("FAIL basic_word%0d: got %0h expected %0h", k, got_data[k], model_word(a, k)); end
      checks++; if (got_last[k] !== (k == FLEN - 1)) begin errors++; $display("FAIL basic_last%0d: got %b expected %b", k, got_last[k], k == FLEN - 1); end
    end
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("FAIL basic_frame_cnt: got %0d expected %0d", frame_cnt, exp_cnt); end
    checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got valid=%b busy=%b expected 0 0", bus.out_valid, busy); end
  endtask

  task automatic test_backpressure();
    logic [511:0] a;
    logic [3:0]   pat;
    logic [W-1:0] held;
    bit           hold;
    bit           done;
    int           n;
    pat = 4'b1001;
    for (int i = 0; i < 16; i++) a[i*32 +: 32] = 32'hA5A5_0000 + 32'(i);
    start_frame(a);
    hold = 1'b0; held = '0; n = 0; done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      if (hold) begin
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== held) begin errors++; $display("FAIL bp_stable: got valid=%b data=%0h expected 1 %0h", bus.out_valid, bus.out_data, held); end
      end
      bus.out_ready = pat[c % 4];
      acc_in = rand_acc();
      hold = bus.out_valid && !bus.out_ready;
      held = bus.out_data;
      if (bus.out_valid && bus.out_ready) begin
        checks++; if (n >= FLEN || bus.out_data !== model_word(a, n)) begin errors++; $display("FAIL bp_word%0d: got %0h expected %0h", n, bus.out_data, model_word(a, n)); end
        checks++; if (bus.out_last !== (n == FLEN - 1)) begin errors++; $display("FAIL bp_last%0d: got %b expected %b", n, bus.out_last, n == FLEN - 1); end
        done = bus.out_last;
        n++;
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    checks++; if (n != FLEN) begin errors++; $display("FAIL bp_count: got %0d expected %0d", n, FLEN); end
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("FAIL bp_frame_cnt: got %0d expected %0d", frame_cnt, exp_cnt); end
  endtask

  task automatic test_random();
    logic [511:0] a;
    for (int f = 0; f < 4; f++) begin
      a = rand_acc();
      start_frame(a);
      collect_frame(int'($urandom_range(100, 30)), 1'b1);
      checks++; if (got_timeout || got_data.size() != FLEN) begin errors++; $display("FAIL rand_len%0d: got %0d expected %0d", f, got_data.size(), FLEN); end
      for (int k = 0; k < got_data.size() && k < FLEN; k++) begin
        checks++; if (got_data[k] !== model_word(a, k) || got_last[k] !== (k == FLEN - 1)) begin errors++; $display("FAIL rand_word%0d_%0d: got %0h/%b expected %0h/%b", f, k, got_data[k], got_last[k], model_word(a, k), k == FLEN - 1); end
      end
      exp_cnt = exp_cnt + 16'd1;
      checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("FAIL rand_frame_cnt%0d: got %0d expected %0d", f, frame_cnt, exp_cnt); end
      repeat (int'($urandom_range(2))) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [511:0] a;
    logic [511:0] b;
    logic [W-1:0] first[$];
    bit           hit;
    a = rand_acc();
    b = 512'd7;
    hit = 1'b0;
    start_frame(a);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 100 && !hit; c++) begin
      if (bus.out_valid) first.push_back(bus.out_data);
      if (bus.out_valid && bus.out_last) begin
        hit = 1'b1;
        acc_in = b;
        snap = 1'b1;
      end
      @(negedge clk);
    end
    snap = 1'b0;
    checks++; if (!hit || first.size() != FLEN) begin errors++; $display("FAIL b2b_first_len: got %0d expected %0d", first.size(), FLEN); end
    for (int k = 0; k < first.size() && k < FLEN; k++) begin
      checks++; if (first[k] !== model_word(a, k)) begin errors++; $display("FAIL b2b_first_word%0d: got %0h expected %0h", k, first[k], model_word(a, k)); end
    end
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd7) begin errors++; $display("FAIL b2b_restart: got valid=%b data=%0h expected 1 7", bus.out_valid, bus.out_data); end
    checks++; if (busy !== 1'b1 || overrun !== 1'b0 || bus.out_last !== 1'b0) begin errors++; $display("FAIL b2b_flags: got busy=%b overrun=%b last=%b expected 1 0 0", busy, overrun, bus.out_last); end
    checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("FAIL b2b_frame_cnt: got %0d expected %0d", frame_cnt, exp_cnt); end
    collect_frame(70, 1'b1);
    checks++; if (got_timeout || got_data.size() != FLEN) begin errors++; $display("FAIL b2b_second_len: got %0d expected %0d", got_data.size(), FLEN); end
    for (int k = 0; k < got_data.size() && k < FLEN; k++) begin
      checks++; if (got_data[k] !== model_word(b, k)) begin errors++; $display("FAIL b2b_second_word%0d: got %0h expected %0h", k, got_data[k], model_word(b, k)); end
    end
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("FAIL b2b_frame_cnt2: got %0d expected %0d", frame_cnt, exp_cnt); end
  endtask

  task automatic test_overrun();
    logic [511:0] a;
    logic [W-1:0] words[$];
    a = rand_acc();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_initial: got %b expected 0", overrun); end
    start_frame(a);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      words.push_back(bus.out_data);
      @(negedge clk);
    end
    words.push_back(bus.out_data);
    acc_in = rand_acc();
    snap = 1'b1;
    @(negedge clk);
    snap = 1'b0;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", overrun); end
    collect_frame(80, 1'b1);
    foreach (got_data[k]) words.push_back(got_data[k]);
    checks++; if (got_timeout || words.size() != FLEN) begin errors++; $display("FAIL ovr_len: got %0d expected %0d", words.size(), FLEN); end
    for (int k = 0; k < words.size() && k < FLEN; k++) begin
      checks++; if (words[k] !== model_word(a, k)) begin errors++; $display("FAIL ovr_word%0d: got %0h expected %0h", k, words[k], model_word(a, k)); end
    end
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("FAIL ovr_frame_cnt: got %0d expected %0d", frame_cnt, exp_cnt); end
    repeat (3) @(negedge clk);
    checks++; if (overrun !== 1'b1 || busy !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL ovr_sticky: got overrun=%b busy=%b valid=%b expected 1 0 0", overrun, busy, bus.out_valid); end
  endtask

  task automatic test_reset_mid();
    logic [511:0] a;
    a = rand_acc();
    start_frame(a);
    bus.out_ready = 1'b1;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    snap = 1'b1;
    acc_in = rand_acc();
    @(negedge clk);
    rst = 1'b0;
    snap = 1'b0;
    bus.out_ready = 1'b0;
    exp_cnt = 16'd0;
    checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got valid=%b busy=%b expected 0 0", bus.out_valid, busy); end
    checks++; if (frame_cnt !== 16'd0 || overrun !== 1'b0) begin errors++; $display("FAIL rstmid_status: got cnt=%0d overrun=%b expected 0 0", frame_cnt, overrun); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_snap: got %b expected 0", bus.out_valid); end
    a = rand_acc();
    start_frame(a);
    collect_frame(60, 1'b1);
    checks++; if (got_timeout || got_data.size() != FLEN) begin errors++; $display("FAIL rstmid_len: got %0d expected %0d", got_data.size(), FLEN); end
    for (int k = 0; k < got_data.size() && k < FLEN; k++) begin
      checks++; if (got_data[k] !== model_word(a, k)) begin errors++; $display("FAIL rstmid_word%0d: got %0h expected %0h", k, got_data[k], model_word(a, k)); end
    end
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("FAIL rstmid_frame_cnt: got %0d expected %0d", frame_cnt, exp_cnt); end
  endtask

  // The counter is preloaded near its top value rather than running
  // 65536 full frames.
  task automatic test_wrap();
    force dut.frame_cnt = 16'hFFFE;
    #1;
    release dut.frame_cnt;
    @(negedge clk);
    exp_cnt = 16'hFFFE;
    for (int f = 0; f < 2; f++) begin
      start_frame(rand_acc());
      collect_frame(100, 1'b0);
      exp_cnt = exp_cnt + 16'd1;
      checks++; if (got_timeout || frame_cnt !== exp_cnt) begin errors++; $display("FAIL wrap%0d: got %0h expected %0h", f, frame_cnt, exp_cnt); end
    end
  endtask

  initial begin
    rst = 1'b1;
    snap = 1'b0;
    acc_in = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
